tmu2_burstfetch: RTL and testbench
==================================

# tmu2_burstfetch

Burst-read sequencer that fills a 64-to-256 TMU2 FIFO from FML memory. It accepts a fetch command (base address, burst count), issues one 4-beat FML read burst at a time, and writes each 64-bit beat into the FIFO write port. It only starts a burst when the FIFO reports room for 8 words, so no beat is ever dropped. It sits between the TMU2 pipeline command source and the FIFO/FML master port.

## Interface
Parameters:
- fml_depth, 26, FML byte-address width.
- cnt_width, 16, width of the burst-count field.

Ports:
- sys_clk  in  1  system clock. One clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- pipe_stb_i  in  1  command valid.
- pipe_ack_o  out  1  command accepted; high exactly when in IDLE.
- adr_i  in  fml_depth  base byte address; bits [4:0] ignored (treated as 0).
- count_i  in  cnt_width  number of 32-byte bursts to fetch.
- busy  out  1  high in any state other than IDLE.
- fml_adr  out  fml_depth  burst address; bits [4:0] always 0.
- fml_stb  out  1  burst request.
- fml_we  out  1  constant 0.
- fml_ack  in  1  burst accepted by memory.
- fml_di  in  64  read data beats.
- fifo_w8avail  in  1  FIFO has at least 8 free 64-bit slots.
- fifo_we  out  1  FIFO write strobe.
- fifo_wd  out  64  FIFO write data.

## Operation
- States: IDLE, WAIT, REQ, DATA. A 2-bit beat counter runs in DATA. Registers: remaining (cnt_width), adr (fml_depth-5 bits, upper address).
- IDLE: pipe_ack_o=1. On pipe_stb_i, latch adr_i[fml_depth-1:5] and count_i.
  - If count_i==0, stay in IDLE. The command is consumed with no FML traffic.
  - Otherwise go to WAIT.
- WAIT: if fifo_w8avail=1, go to REQ. Otherwise hold.
- REQ: fml_stb=1 and fml_adr={adr,5'b0}. These stay stable until fml_ack. On fml_stb & fml_ack, go to DATA with beat=0.
- DATA: fifo_we=1 every cycle, fifo_wd=fml_di (combinational pass-through). Beat increments each cycle.
  - On beat 3: remaining -= 1 and adr += 1 (32-byte stride, wraps modulo 2^fml_depth).
  - Then go to IDLE if the decremented remaining is 0, else go to WAIT.
- Flow-control invariant: this block is the only FIFO writer. w8avail is sampled before every burst, and at most one burst is in flight, so fifo_we is never asserted while the FIFO is full.
- fml_ack outside REQ is ignored.
- Reset values: state=IDLE, pipe_ack_o=1, busy=0, fml_stb=0, fml_we=0, fml_adr=0, fifo_we=0, fifo_wd=fml_di (don't care), remaining=0, adr=0.
- Reset mid-operation: immediate return to IDLE. Any in-flight burst is abandoned and no further fifo_we is issued. A system-wide reset is assumed to reset FML and the FIFO too.

## Timing
- Accept cycle N (IDLE, stb) → WAIT at N+1 → REQ at N+2 at the earliest (fml_stb high).
- Ack in cycle M → beats written in M+1..M+4. FML delivers beat 0 the cycle after ack, consecutively.
- Minimum per-burst period: 6 cycles (WAIT 1, REQ 1, DATA 4).
- Last beat at cycle L → pipe_ack_o high at L+1, so a new command can be accepted at L+1.
- A zero-count command accepted at N leaves pipe_ack_o high at N+1.
- fml_stb, fml_adr, pipe_ack_o and busy come from state registers, with no combinational path from inputs. Only fifo_we/fifo_wd depend combinationally on state and fml_di.

## Structure
- Shared tmu2 constants header holds:
  - FML burst length (4 beats)
  - burst byte stride (32)
  - address alignment shift (5)
- State encoding uses localparams local to this module.
- Single module. No sub-module is warranted; the beat counter and address/count registers are trivial.

## Test plan
- Reset, then idle: all outputs at reset values, fml_stb=0, pipe_ack_o=1, busy=0.
- adr_i=0x100000, count_i=2, fifo_w8avail=1, ack after 3 cycles:
  - fml_adr=0x100000 then 0x100020
  - exactly 8 fifo_we pulses, data matching fml_di
  - pipe_ack_o returns the cycle after the 8th beat.
- count_i=0: accepted in one cycle, no fml_stb, pipe_ack_o high next cycle.
- fifo_w8avail=0 for 20 cycles after acceptance: stays in WAIT with fml_stb=0. It goes to REQ the cycle after w8avail rises.
- adr_i=0x3FFFFE0 (fml_depth=26), count_i=2: second burst address wraps to 0x0000000.
- sys_rst asserted during DATA beat 1: next cycle fifo_we=0, fml_stb=0, IDLE. A new count_i=1 command then completes normally with 4 beats.

Source files
------------

// File: rtl/tmu2_burstfetch_pkg.sv
// Constants shared by the TMU2 burst-fetch logic: FML burst geometry and address alignment.
package tmu2_burstfetch_pkg;

  localparam int unsigned FML_BURST_LEN = 4;   // 64-bit beats per FML burst
  localparam int unsigned BURST_STRIDE  = 32;  // bytes covered by one burst
  localparam int unsigned ADR_SHIFT     = 5;   // log2(BURST_STRIDE)

endpackage

// File: rtl/tmu2_burstfetch_if.sv
// Command, FML master and FIFO write-port signals of the burst fetcher, bundled as one interface.
interface tmu2_burstfetch_if #(
  parameter int fml_depth = 26,
  parameter int cnt_width = 16
);

  logic                 pipe_stb_i;
  logic                 pipe_ack_o;
  logic [fml_depth-1:0] adr_i;
  logic [cnt_width-1:0] count_i;
  logic                 busy;
  logic [fml_depth-1:0] fml_adr;
  logic                 fml_stb;
  logic                 fml_we;
  logic                 fml_ack;
  logic [63:0]          fml_di;
  logic                 fifo_w8avail;
  logic                 fifo_we;
  logic [63:0]          fifo_wd;

  // master: the fetch sequencer itself
  modport master (
    input  pipe_stb_i, adr_i, count_i, fml_ack, fml_di, fifo_w8avail,
    output pipe_ack_o, busy, fml_adr, fml_stb, fml_we, fifo_we, fifo_wd
  );

  // slave: command source, FML memory and FIFO surrounding the sequencer
  modport slave (
    output pipe_stb_i, adr_i, count_i, fml_ack, fml_di, fifo_w8avail,
    input  pipe_ack_o, busy, fml_adr, fml_stb, fml_we, fifo_we, fifo_wd
  );

endinterface

// File: rtl/tmu2_burstfetch.sv
// Burst-read sequencer: fetches count_i 32-byte FML bursts into the TMU2 FIFO, one burst in flight,
// starting each burst only once the FIFO reports room for 8 words.
module tmu2_burstfetch
  import tmu2_burstfetch_pkg::*;
#(
  parameter int fml_depth = 26,
  parameter int cnt_width = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  tmu2_burstfetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(FML_BURST_LEN - 1);

  state_t                         state_reg, state_next;
  logic [1:0]                     beat_reg, beat_next;
  logic [cnt_width-1:0]           remaining_reg, remaining_next;
  logic [fml_depth-ADR_SHIFT-1:0] adr_reg, adr_next;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= S_IDLE;
      beat_reg      <= '0;
      remaining_reg <= '0;
      adr_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      remaining_reg <= remaining_next;
      adr_reg       <= adr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    remaining_next = remaining_reg;
    adr_next       = adr_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.pipe_stb_i) begin
          adr_next       = bus.adr_i[fml_depth-1:ADR_SHIFT];
          remaining_next = bus.count_i;
          // A zero-count command is consumed without touching FML.
          if (bus.count_i != '0)
            state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.fifo_w8avail)
          state_next = S_REQ;
      end
      S_REQ: begin
        if (bus.fml_ack) begin
          state_next = S_DATA;
          beat_next  = '0;
        end
      end
      S_DATA: begin
        beat_next = beat_reg + 2'd1;
        if (beat_reg == LAST_BEAT) begin
          remaining_next = remaining_reg - 1'b1;
          // Upper address wraps naturally, giving a modulo-2^fml_depth byte address.
          adr_next       = adr_reg + 1'b1;
          state_next     = (remaining_next == '0) ? S_IDLE : S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.pipe_ack_o = (state_reg == S_IDLE);
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.fml_stb    = (state_reg == S_REQ);
  assign bus.fml_adr    = {adr_reg, {ADR_SHIFT{1'b0}}};
  assign bus.fml_we     = 1'b0;
  assign bus.fifo_we    = (state_reg == S_DATA);
  assign bus.fifo_wd    = bus.fml_di;

endmodule

// File: tb/tb_tmu2_burstfetch.sv
// Self-checking bench for tmu2_burstfetch: table of fetch commands plus a mid-burst reset sequence.
module tb_tmu2_burstfetch;
  import tmu2_burstfetch_pkg::*;

  localparam int FD = 26;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmu2_burstfetch_if #(.fml_depth(FD), .cnt_width(CW)) bus();

  tmu2_burstfetch #(.fml_depth(FD), .cnt_width(CW)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [25:0] adr;
    logic [15:0] cnt;
    int          ackd;
    int          w8hold;
    bit          spur;
    int          nb;
    logic [25:0] ea0;
    logic [25:0] ea1;
    logic [25:0] ea2;
  } vec_t;

  logic [25:0] obs_adr [8];
  int obs_n, beats, first_stb, last_we, done_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and act as FML memory/FIFO until pipe_ack_o returns.
  task automatic run_cmd(input string tag, input logic [25:0] a, input logic [15:0] c,
                         input int ackd, input int w8hold, input bit spur);
    int  stb_run = 0;
    int  since   = 100;
    int  cyc     = 0;
    bit  done    = 1'b0;
    obs_n = 0; beats = 0; first_stb = -1; last_we = -1; done_cyc = -1;
    check({tag, " ready"}, bus.pipe_ack_o, 1);
    bus.pipe_stb_i   = 1'b1;
    bus.adr_i        = a;
    bus.count_i      = c;
    bus.fifo_w8avail = (w8hold == 0);
    tick();
    bus.pipe_stb_i = 1'b0;
    bus.adr_i      = 26'($urandom);
    bus.count_i    = 16'($urandom);
    while (!done && cyc < 2000) begin
      bus.fml_di       = {$urandom, $urandom};
      bus.fifo_w8avail = (cyc >= w8hold);
      bus.fml_ack      = bus.fml_stb ? (stb_run == ackd) : spur;
      #1;
      if (bus.pipe_ack_o) begin
        done     = 1'b1;
        done_cyc = cyc;
        check({tag, " busy_idle"}, bus.busy, 0);
      end else begin
        check({tag, " busy"}, bus.busy, 1);
        check({tag, " fifo_we"}, bus.fifo_we, (since >= 1 && since <= 4));
        if (bus.fifo_we) begin
          beats++;
          last_we = cyc;
          check({tag, " fifo_wd"}, bus.fifo_wd, bus.fml_di);
        end
        if (bus.fml_stb && stb_run == 0) begin
          if (obs_n < 8) obs_adr[obs_n] = bus.fml_adr;
          obs_n++;
          if (first_stb < 0) first_stb = cyc;
        end
        since   = (bus.fml_stb && bus.fml_ack) ? 1 : since + 1;
        stb_run = bus.fml_stb ? stb_run + 1 : 0;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    bus.fml_ack = 1'b0;
    if (!done) check({tag, " timeout"}, 0, 1);
  endtask

  task automatic verify(input vec_t v);
    logic [25:0] ea [3];
    ea[0] = v.ea0; ea[1] = v.ea1; ea[2] = v.ea2;
    check({v.name, " beats"}, beats, 4 * int'(v.cnt));
    check({v.name, " bursts"}, obs_n, v.nb);
    for (int i = 0; i < v.nb && i < 3 && i < obs_n; i++)
      check($sformatf("%s adr%0d", v.name, i), obs_adr[i], ea[i]);
    if (v.cnt != 0) begin
      check({v.name, " ack_after_last"}, done_cyc, last_we + 1);
      check({v.name, " first_req"}, first_stb, v.w8hold + 1);
    end else begin
      check({v.name, " zero_done"}, done_cyc, 0);
    end
  endtask

  vec_t vecs [5];
  vec_t post;

  initial begin
    bus.pipe_stb_i   = 1'b0;
    bus.adr_i        = '0;
    bus.count_i      = '0;
    bus.fml_ack      = 1'b0;
    bus.fml_di       = '0;
    bus.fifo_w8avail = 1'b0;

    vecs[0] = '{"two_bursts", 26'h0100000, 16'd2, 3, 0,  1'b0, 2, 26'h0100000, 26'h0100020, 26'h0};
    vecs[1] = '{"zero_count", 26'h0000000, 16'd0, 0, 0,  1'b0, 0, 26'h0,       26'h0,       26'h0};
    vecs[2] = '{"unaligned",  26'h123457F, 16'd1, 0, 0,  1'b1, 1, 26'h1234560, 26'h0,       26'h0};
    vecs[3] = '{"wrap",       26'h3FFFFE0, 16'd2, 1, 0,  1'b0, 2, 26'h3FFFFE0, 26'h0000000, 26'h0};
    vecs[4] = '{"w8_stall",   26'h0000040, 16'd3, 2, 20, 1'b1, 3, 26'h0000040, 26'h0000060, 26'h0000080};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst pipe_ack", bus.pipe_ack_o, 1);
    check("rst busy", bus.busy, 0);
    check("rst fml_stb", bus.fml_stb, 0);
    check("rst fml_we", bus.fml_we, 0);
    check("rst fml_adr", bus.fml_adr, 0);
    check("rst fifo_we", bus.fifo_we, 0);

    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i].name, vecs[i].adr, vecs[i].cnt, vecs[i].ackd, vecs[i].w8hold, vecs[i].spur);
      verify(vecs[i]);
      $display("cmd %s adr=%07h cnt=%0d bursts=%0d beats=%0d", vecs[i].name, vecs[i].adr,
               vecs[i].cnt, obs_n, beats);
    end

    // Reset while the second beat of a burst is being written.
    bus.pipe_stb_i   = 1'b1;
    bus.adr_i        = 26'h0000200;
    bus.count_i      = 16'd3;
    bus.fifo_w8avail = 1'b1;
    tick();
    bus.pipe_stb_i = 1'b0;
    tick();
    check("mid fml_stb", bus.fml_stb, 1);
    bus.fml_ack = 1'b1;
    tick();
    bus.fml_ack = 1'b0;
    check("mid beat0", bus.fifo_we, 1);
    tick();
    check("mid beat1", bus.fifo_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst fifo_we", bus.fifo_we, 0);
    check("mid_rst fml_stb", bus.fml_stb, 0);
    check("mid_rst pipe_ack", bus.pipe_ack_o, 1);
    check("mid_rst busy", bus.busy, 0);
    check("mid_rst fml_adr", bus.fml_adr, 0);
    tick();
    check("mid_rst quiet", bus.fifo_we, 0);
    $display("cmd mid_reset abandoned burst at beat 1");

    post = '{"post_rst", 26'h00000A0, 16'd1, 0, 0, 1'b0, 1, 26'h00000A0, 26'h0, 26'h0};
    run_cmd(post.name, post.adr, post.cnt, post.ackd, post.w8hold, post.spur);
    verify(post);
    $display("cmd %s adr=%07h cnt=%0d bursts=%0d beats=%0d", post.name, post.adr, post.cnt,
             obs_n, beats);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
